// File: rtl/opr_fetch.sv
// Operand fetch stage: 31-entry register file, exe/mem/wb forwarding with
// hazard detection, and a one-deep registered output behind a valid/ready handshake.
// Optional build macro: OPR_FETCH_PERF_CNT_EN adds a 32-bit stall_cnt output.

package basic;
    localparam int unsigned XLEN_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [XLEN_W-1:0] UIntX;
    typedef logic [REG_W-1:0]  RegSel;

    // Producer broadcast from a later pipeline stage
    typedef struct packed {
        logic  valid;
        logic  fwdable;
        RegSel addr;
        UIntX  wdata;
    } FwCtrl;
endpackage

module opr_fetch
    import basic::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    output logic            id_ready,
    input  RegSel           id_rs1,
    input  RegSel           id_rs2,
    input  logic            id_rs1_used,
    input  logic            id_rs2_used,
    input  FwCtrl           exe_fw,
    input  FwCtrl           mem_fw,
    input  FwCtrl           wb_fw,
    input  logic            wb_commit,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            stall
`ifdef OPR_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    logic [XLEN-1:0] rf_q [1:31];

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;

    logic [XLEN-1:0] rf1_val, rf2_val;
    logic [XLEN-1:0] op1_val, op2_val;
    logic            op1_haz, op2_haz;
    logic            accept;

    // First matching producer wins; a non-forwardable match is a hazard and blocks lower sources
    function automatic void resolve(
        input  RegSel           addr,
        input  logic            used,
        input  logic [XLEN-1:0] rf_val,
        input  FwCtrl           e,
        input  FwCtrl           m,
        input  FwCtrl           w,
        output logic            haz,
        output logic [XLEN-1:0] val
    );
        haz = 1'b0;
        val = '0;
        if (used && (addr != RegSel'(0))) begin
            if (e.valid && (e.addr == addr)) begin
                haz = !e.fwdable;
                val = XLEN'(e.wdata);
            end else if (m.valid && (m.addr == addr)) begin
                haz = !m.fwdable;
                val = XLEN'(m.wdata);
            end else if (w.valid && (w.addr == addr)) begin
                haz = !w.fwdable;
                val = XLEN'(w.wdata);
            end else begin
                val = rf_val;
            end
        end
    endfunction

    // Register file write port; x0 is not stored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_commit && (wb_fw.addr != RegSel'(0))) begin
            rf_q[wb_fw.addr] <= XLEN'(wb_fw.wdata);
        end
    end

    // Operand resolution, hazard detection and acceptance
    always_comb begin
        rf1_val = '0;
        rf2_val = '0;
        if (id_rs1 != RegSel'(0)) rf1_val = rf_q[id_rs1];
        if (id_rs2 != RegSel'(0)) rf2_val = rf_q[id_rs2];
        resolve(id_rs1, id_rs1_used, rf1_val, exe_fw, mem_fw, wb_fw, op1_haz, op1_val);
        resolve(id_rs2, id_rs2_used, rf2_val, exe_fw, mem_fw, wb_fw, op2_haz, op2_val);
    end

    assign stall    = id_valid && (op1_haz || op2_haz);
    assign id_ready = !stall && (!out_valid_q || out_ready) && !flush && !reset;
    assign accept   = id_valid && id_ready;

    // Output register next state: flush kills, accept captures, ready drains
    always_comb begin
        out_valid_d = out_valid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            rs1_d       = op1_val;
            rs2_d       = op2_val;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
        end
    end

    assign out_valid = out_valid_q;
    assign rs1_data  = rs1_q;
    assign rs2_data  = rs2_q;

`ifdef OPR_FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Stall cycle counter, wraps naturally
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Stall counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    // Stall counter not built
`endif

endmodule

// File: tb/tb_opr_fetch.sv
// Directed bench for opr_fetch: forwarding priority, hazards, handshake, flush, reset.
module tb_opr_fetch;
    import basic::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic        id_ready;
    RegSel       id_rs1, id_rs2;
    logic        id_rs1_used, id_rs2_used;
    FwCtrl       exe_fw, mem_fw, wb_fw;
    logic        wb_commit;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rs1_data, rs2_data;
    logic        stall;
`ifdef OPR_FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    opr_fetch #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .exe_fw      (exe_fw),
        .mem_fw      (mem_fw),
        .wb_fw       (wb_fw),
        .wb_commit   (wb_commit),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .stall       (stall)
`ifdef OPR_FETCH_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic FwCtrl fw(input logic v, input logic f, input RegSel a, input logic [31:0] d);
        fw = {v, f, a, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input RegSel r1, input logic u1, input RegSel r2, input logic u2);
        id_valid    = 1'b1;
        id_rs1      = r1;
        id_rs1_used = u1;
        id_rs2      = r2;
        id_rs2_used = u2;
    endtask

    initial begin
        reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        exe_fw = '0; mem_fw = '0; wb_fw = '0; wb_commit = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rs1", rs1_data, 32'd0);
        chk("rst_rs2", rs2_data, 32'd0);
        chk("rst_id_ready", 32'(id_ready), 32'd0);
        step(); step();
        reset = 1'b0;

        // Register file write then read of x5
        wb_fw = fw(1'b1, 1'b1, 5'd5, 32'h1234); wb_commit = 1'b1;
        step();
        wb_fw = '0; wb_commit = 1'b0;
        issue(5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        chk("rf_id_ready", 32'(id_ready), 32'd1);
        chk("rf_stall", 32'(stall), 32'd0);
        step();
        chk("rf_out_valid", 32'(out_valid), 32'd1);
        chk("rf_rs1", rs1_data, 32'h1234);
        chk("rf_rs2_unused", rs2_data, 32'd0);
        id_valid = 1'b0;
        step();
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // exe beats mem
        exe_fw = fw(1'b1, 1'b1, 5'd5, 32'hAA);
        mem_fw = fw(1'b1, 1'b1, 5'd5, 32'hBB);
        issue(5'd5, 1'b1, 5'd0, 1'b0);
        step();
        chk("exe_prio_rs1", rs1_data, 32'hAA);
        // mem beats wb
        exe_fw = '0;
        wb_fw  = fw(1'b1, 1'b1, 5'd5, 32'hCC);
        issue(5'd1, 1'b0, 5'd5, 1'b1);
        step();
        chk("mem_prio_rs2", rs2_data, 32'hBB);
        chk("unused_rs1", rs1_data, 32'd0);
        // same-cycle write and read of x6 forwards wb data
        mem_fw = '0;
        wb_fw  = fw(1'b1, 1'b1, 5'd6, 32'h77); wb_commit = 1'b1;
        issue(5'd6, 1'b1, 5'd6, 1'b1);
        step();
        chk("wb_fwd_rs1", rs1_data, 32'h77);
        wb_fw = '0; wb_commit = 1'b0;
        issue(5'd5, 1'b1, 5'd6, 1'b1);
        step();
        chk("rf_x6_rs2", rs2_data, 32'h77);
        chk("rf_x5_rs1", rs1_data, 32'h1234);

        // Non-forwardable exe match stalls, no fall-through to mem
        exe_fw = fw(1'b1, 1'b0, 5'd7, 32'hDEAD);
        mem_fw = fw(1'b1, 1'b1, 5'd7, 32'h99);
        issue(5'd0, 1'b0, 5'd7, 1'b1);
        #1;
        chk("haz_stall", 32'(stall), 32'd1);
        chk("haz_id_ready", 32'(id_ready), 32'd0);
        step();
        chk("haz_no_capture", 32'(out_valid), 32'd0);
        exe_fw = '0;
        mem_fw = fw(1'b1, 1'b1, 5'd7, 32'h55);
        #1;
        chk("haz_clear_stall", 32'(stall), 32'd0);
        step();
        chk("haz_mem_rs2", rs2_data, 32'h55);
        mem_fw = '0;

        // x0 and unused operands never hazard
        exe_fw = fw(1'b1, 1'b0, 5'd0, 32'hFFFF);
        issue(5'd0, 1'b1, 5'd9, 1'b0);
        #1;
        chk("x0_stall", 32'(stall), 32'd0);
        exe_fw = fw(1'b1, 1'b0, 5'd9, 32'hFFFF);
        #1;
        chk("unused_stall", 32'(stall), 32'd0);
        step();
        chk("x0_rs1", rs1_data, 32'd0);
        chk("unused_rs2", rs2_data, 32'd0);
        exe_fw = '0;

        // Backpressure holds data, then flush kills
        issue(5'd5, 1'b1, 5'd0, 1'b0);
        step();
        chk("bp_rs1", rs1_data, 32'h1234);
        out_ready = 1'b0;
        issue(5'd6, 1'b1, 5'd0, 1'b0);
        #1;
        chk("bp_id_ready", 32'(id_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_rs1", rs1_data, 32'h1234);
        end
        flush = 1'b1;
        #1;
        chk("flush_id_ready", 32'(id_ready), 32'd0);
        step();
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_no_capture", rs1_data, 32'h1234);
        flush = 1'b0;

        // Reset mid-handshake
        step();
        chk("pre_rst_rs1", rs1_data, 32'h77);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_rs1", rs1_data, 32'd0);
        chk("arst_id_ready", 32'(id_ready), 32'd0);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        issue(5'd5, 1'b1, 5'd6, 1'b1);
        step();
        chk("post_rst_x5", rs1_data, 32'd0);
        chk("post_rst_x6", rs2_data, 32'd0);

        // Four stall cycles
        exe_fw = fw(1'b1, 1'b0, 5'd3, 32'd0);
        issue(5'd3, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("stall4_out_valid", 32'(out_valid), 32'd0);
`ifdef OPR_FETCH_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, 32'd4);
`endif
        id_valid = 1'b0;
        exe_fw = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
